// File: rtl/aes_host_pkg.sv
// aes_host_pkg: register map, command codes and sequencer states for the AES host driver
package aes_host_pkg;
  localparam logic [7:0] ADDR_CMD = 8'd1;
  localparam logic [7:0] ADDR_STATUS = 8'd2;
  localparam logic [7:0] ADDR_INP = 8'd3;
  localparam logic [7:0] ADDR_OUTP_BASE = 8'd4;
  localparam logic [31:0] CMD_SEND_INPUT = 32'd1;
  localparam logic [31:0] CMD_GET_OUTPUT = 32'd2;
  localparam logic [31:0] CMD_START = 32'd3;
  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_CMD_IN, ST_WR_WORD, ST_POLL_IN, ST_CLR_IN,
    ST_CMD_OUT, ST_POLL_OUT, ST_RD_WORD, ST_CLR_OUT, ST_DELIVER, ST_GAP
  } state_t;
endpackage

// File: rtl/aes_host_bus_op.sv
// aes_host_bus_op: single Avalon-MM access engine; freezes the request while the slave stalls
module aes_host_bus_op (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req,
  input  logic        rnw,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        avm_chipselect,
  output logic [7:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);
  logic pend, pend_rnw, active, cur_rnw;
  logic [7:0] pend_addr, cur_addr;
  logic [31:0] pend_wdata, cur_wdata;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend <= 1'b0;
      pend_rnw <= 1'b0;
      pend_addr <= '0;
      pend_wdata <= '0;
    end else begin
      pend <= active && avm_waitrequest;
      if (!pend) begin
        pend_rnw <= rnw;
        pend_addr <= addr;
        pend_wdata <= wdata;
      end
    end
  end
  // once stalled, the captured request drives the bus regardless of the sequencer
  always_comb begin
    active = req || pend;
    cur_rnw = pend ? pend_rnw : rnw;
    cur_addr = pend ? pend_addr : addr;
    cur_wdata = pend ? pend_wdata : wdata;
    avm_chipselect = active;
    avm_read = active && cur_rnw;
    avm_write = active && !cur_rnw;
    avm_address = active ? cur_addr : '0;
    avm_writedata = avm_write ? cur_wdata : '0;
    done = active && !avm_waitrequest;
    rdata = avm_readdata;
  end
endmodule

// File: rtl/aes_avalon_host_driver.sv
// aes_avalon_host_driver: Avalon-MM sequencer running the AES-256 decrypt register protocol per block
// AES_HOST_TIMEOUT_EN: bound each status poll phase to POLL_LIMIT reads and flag a sticky error
module aes_avalon_host_driver #(
  parameter int GAP_CYCLES = 2,
  parameter int POLL_LIMIT = 1024
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         avm_chipselect,
  output logic [7:0]   avm_address,
  output logic         avm_read,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic [31:0]  avm_readdata,
  input  logic         avm_waitrequest,
  output logic         busy,
  output logic         error
);
  import aes_host_pkg::*;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam bit NO_GAP = GAP_CYCLES == 0;
  state_t state, state_n, ret, ret_n, after_clr;
  logic armed, req, rnw, done, timeout;
  logic [1:0] k;
  logic [GW-1:0] gap_cnt;
  logic [127:0] blk;
  logic [7:0] addr;
  logic [31:0] wdata, rdata;

  aes_host_bus_op u_bus (
    .clock(clock), .resetn(resetn), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .avm_chipselect(avm_chipselect), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

`ifdef AES_HOST_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;
  logic err_q;
  assign timeout = done && !rdata[0] && poll_cnt == PW'(POLL_LIMIT - 1);
  assign error = err_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      poll_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      poll_cnt <= (state == ST_POLL_IN || state == ST_POLL_OUT) ? poll_cnt + PW'(done && !rdata[0]) : '0;
      err_q <= err_q || timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif

  assign in_ready = state == ST_IDLE;
  assign out_valid = state == ST_DELIVER;
  assign busy = state != ST_IDLE;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_INIT;
      ret <= ST_IDLE;
      armed <= 1'b0;
      k <= '0;
      gap_cnt <= '0;
      blk <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      armed <= 1'b1;
      gap_cnt <= state == ST_GAP ? gap_cnt + 1'b1 : '0;
      if (in_valid && in_ready) blk <= in_data;
      if (done && state == ST_WR_WORD) blk <= {blk[95:0], 32'h0};
      if (done && state == ST_RD_WORD) out_data <= {out_data[95:0], rdata};
      if (done && (state == ST_WR_WORD || state == ST_RD_WORD)) k <= k + 1'b1;
    end
  end

  // armed keeps the first cycle after reset strobe-free before START is issued
  always_comb begin
    state_n = state;
    ret_n = ret;
    req = 1'b0;
    rnw = 1'b0;
    addr = ADDR_CMD;
    wdata = '0;
    after_clr = state == ST_CLR_IN ? ST_CMD_OUT : ST_DELIVER;
    case (state)
      ST_INIT: begin
        req = armed;
        wdata = CMD_START;
        if (done) begin
          state_n = NO_GAP ? ST_IDLE : ST_GAP;
          ret_n = ST_IDLE;
        end
      end
      ST_IDLE: if (in_valid) state_n = ST_CMD_IN;
      ST_CMD_IN: begin
        req = 1'b1;
        wdata = CMD_SEND_INPUT;
        if (done) state_n = ST_WR_WORD;
      end
      ST_WR_WORD: begin
        req = 1'b1;
        addr = ADDR_INP;
        wdata = blk[127:96];
        if (done && k == 2'd3) state_n = ST_POLL_IN;
      end
      ST_POLL_IN, ST_POLL_OUT: begin
        req = 1'b1;
        rnw = 1'b1;
        addr = ADDR_STATUS;
        if (timeout) state_n = ST_IDLE;
        else if (done && rdata[0]) state_n = state == ST_POLL_IN ? ST_CLR_IN : ST_RD_WORD;
      end
      ST_CLR_IN, ST_CLR_OUT: begin
        req = 1'b1;
        addr = ADDR_STATUS;
        if (done) begin
          state_n = NO_GAP ? after_clr : ST_GAP;
          ret_n = after_clr;
        end
      end
      ST_CMD_OUT: begin
        req = 1'b1;
        wdata = CMD_GET_OUTPUT;
        if (done) state_n = ST_POLL_OUT;
      end
      ST_RD_WORD: begin
        req = 1'b1;
        rnw = 1'b1;
        addr = ADDR_OUTP_BASE + {6'd0, k};
        if (done && k == 2'd3) state_n = ST_CLR_OUT;
      end
      ST_DELIVER: if (out_ready) state_n = ST_IDLE;
      ST_GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = ret;
      default: state_n = ST_INIT;
    endcase
  end
endmodule

// File: tb/tb_aes_avalon_host_driver.sv
// tb_aes_avalon_host_driver: scoreboard bench with a behavioural AES register slave
module tb_aes_avalon_host_driver;
  localparam int GAP = 2;
`ifdef AES_HOST_TIMEOUT_EN
  localparam int PL = 8;
`else
  localparam int PL = 1024;
`endif
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [127:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic avm_waitrequest = 1'b0;
  logic in_ready, out_valid, avm_chipselect, avm_read, avm_write, busy, error;
  logic [127:0] out_data;
  logic [7:0] avm_address;
  logic [31:0] avm_writedata;
  int n_chk = 0, n_fail = 0;
  logic [40:0] exp_op_q[$];
  logic [127:0] exp_out_q[$];
  int poll_q[$];
  logic [127:0] plain_q[$];
  int polls_seen = 0;
  bit wr_rand = 0, rdy_rand = 0;
  logic done_v = 1'b0, done_wr = 1'b0;
  logic [7:0] done_addr = '0;

  always #5 clock = ~clock;

  aes_avalon_host_driver #(.GAP_CYCLES(GAP), .POLL_LIMIT(PL)) dut (
    .clock(clock), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .avm_chipselect(avm_chipselect), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .error(error)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [40:0] op(input bit w, input int a, input logic [31:0] d);
    return {w, 8'(a), d};
  endfunction

  // slave: registers update on completed ops, read data and stalls driven just after the edge
  initial forever begin
    @(posedge clock);
    if (!resetn) polls_seen = 0;
    else if (done_v) begin
      if (done_wr && done_addr == 8'd2) begin
        polls_seen = 0;
        if (poll_q.size() > 0) void'(poll_q.pop_front());
      end
      if (!done_wr && done_addr == 8'd2) polls_seen++;
      if (!done_wr && done_addr == 8'd7 && plain_q.size() > 0) void'(plain_q.pop_front());
    end
    #1;
    avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (avm_address == 8'd2) avm_readdata = {31'd0, poll_q.size() > 0 && polls_seen + 1 >= poll_q[0]};
    else if (avm_address >= 8'd4 && avm_address <= 8'd7 && plain_q.size() > 0)
      avm_readdata = 32'(plain_q[0] >> (32 * (7 - int'(avm_address))));
    else avm_readdata = 32'h0;
  end

  // monitor: bus ops and output handshakes checked against the scoreboard queues
  initial begin
    logic prev_stall = 1'b0, prev_ov_wait = 1'b0;
    logic [42:0] prev_bus = '0;
    logic [127:0] prev_out = '0;
    forever begin
      @(negedge clock);
      done_v = resetn && avm_chipselect && !avm_waitrequest;
      done_wr = avm_write;
      done_addr = avm_address;
      if (resetn && prev_stall)
        check("hold_bus", {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata}, prev_bus);
      if (resetn && avm_chipselect) check("one_strobe", avm_read & avm_write, 0);
      if (done_v) begin
        if (exp_op_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bus_op: unexpected op wr=%b addr=%0d data=%h", avm_write, avm_address, avm_writedata);
        end else check("bus_op", {avm_write, avm_address, avm_write ? avm_writedata : 32'h0}, exp_op_q.pop_front());
      end
      if (resetn && prev_ov_wait) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_out_data", out_data, prev_out);
      end
      if (resetn && out_valid) begin
        check("no_in_ready_in_deliver", in_ready, 0);
        if (out_ready) begin
          if (exp_out_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_data: unexpected block %h", out_data);
          end else check("out_data", out_data, exp_out_q.pop_front());
        end
      end
      if (resetn) check("busy_vs_idle", busy, !in_ready);
      prev_stall = resetn && avm_chipselect && avm_waitrequest;
      prev_bus = {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata};
      prev_ov_wait = resetn && out_valid && !out_ready;
      prev_out = out_data;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(in_ready && exp_op_q.size() == 0 && exp_out_q.size() == 0) && t < 3000) begin
      cyc();
      t++;
    end
    if (t >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout in_ready=%b ops_left=%0d outs_left=%0d", name, in_ready, exp_op_q.size(), exp_out_q.size());
    end
  endtask

  task automatic accept(input logic [127:0] data);
    int t = 0;
    while (!in_ready && t < 3000) begin
      cyc();
      t++;
    end
    if (t >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept: in_ready never rose");
    end
    in_data = data;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] data, input int pin, input int pout, input logic [127:0] plain);
    exp_op_q.push_back(op(1, 1, 1));
    for (int i = 0; i < 4; i++) exp_op_q.push_back(op(1, 3, 32'(data >> (96 - 32 * i))));
    repeat (pin) exp_op_q.push_back(op(0, 2, 0));
    exp_op_q.push_back(op(1, 2, 0));
    exp_op_q.push_back(op(1, 1, 2));
    repeat (pout) exp_op_q.push_back(op(0, 2, 0));
    for (int i = 0; i < 4; i++) exp_op_q.push_back(op(0, 4 + i, 0));
    exp_op_q.push_back(op(1, 2, 0));
    exp_out_q.push_back(plain);
    poll_q.push_back(pin);
    poll_q.push_back(pout);
    plain_q.push_back(plain);
    accept(data);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_op_q.delete();
    exp_out_q.delete();
    poll_q.delete();
    plain_q.delete();
    cyc(2);
    exp_op_q.push_back(op(1, 1, 3));
    resetn = 1'b1;
    wait_idle("reinit");
  endtask

  initial begin
    int t;
    cyc(3);
    check("rst_cs", avm_chipselect, 0);
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1);
    check("rst_error", error, 0);
    exp_op_q.push_back(op(1, 1, 3));
    resetn = 1'b1;
    wait_idle("init");
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);

    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 3, 1, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
    t = 0;
    while (!out_valid && t < 200) begin
      cyc();
      t++;
    end
    check("first_out_valid", out_valid, 1);
    check("first_out_data", out_data, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
    cyc(5);
    check("held_out_valid", out_valid, 1);
    check("held_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    check("valid_drop", out_valid, 0);
    wait_idle("directed");

    wr_rand = 1;
    rdy_rand = 1;
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 3, 1, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
    for (int b = 0; b < 6; b++)
      send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 4), $urandom_range(1, 4),
                 {$urandom, $urandom, $urandom, $urandom});
    wait_idle("random");
    wr_rand = 0;
    rdy_rand = 0;
    out_ready = 1'b1;

`ifdef AES_HOST_TIMEOUT_EN
    begin
      logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
      exp_op_q.push_back(op(1, 1, 1));
      for (int i = 0; i < 4; i++) exp_op_q.push_back(op(1, 3, 32'(d >> (96 - 32 * i))));
      repeat (PL) exp_op_q.push_back(op(0, 2, 0));
      poll_q.push_back(100000);
      accept(d);
      t = 0;
      while (!error && t < 200) begin
        cyc();
        t++;
      end
      check("timeout_error", error, 1);
      wait_idle("timeout_idle");
      check("timeout_out_valid", out_valid, 0);
      do_reset();
      check("error_cleared", error, 0);
    end
`endif

    send_block({$urandom, $urandom, $urandom, $urandom}, 1, 2, {$urandom, $urandom, $urandom, $urandom});
    t = 0;
    while (!(avm_read && avm_address == 8'd6) && t < 200) begin
      cyc();
      t++;
    end
    check("reached_rd_word2", avm_read && avm_address == 8'd6, 1);
    resetn = 1'b0;
    exp_op_q.delete();
    exp_out_q.delete();
    poll_q.delete();
    plain_q.delete();
    cyc();
    check("mid_rst_read", avm_read, 0);
    check("mid_rst_write", avm_write, 0);
    check("mid_rst_cs", avm_chipselect, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 1);
    exp_op_q.push_back(op(1, 1, 3));
    resetn = 1'b1;
    wait_idle("reinit_after_abort");
    send_block({$urandom, $urandom, $urandom, $urandom}, 2, 1, {$urandom, $urandom, $urandom, $urandom});
    wait_idle("post_reset_block");
    check("final_error", error, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
